alu_arbiter: RTL and testbench

- Shares one 4-bit combinational ALU instance between two requesters using round-robin arbitration.
- Per operation: accepts an {A, B, opcode} request over a valid/ready handshake, drives the ALU from registered operands, waits EXEC_CYCLES, captures result and flags, then returns them with the requester ID over a valid/ready response channel.
- Sits between the ALU and its clients; the ALU is instantiated outside this block.

---
 rtl/alu_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one external ALU between two requesters
// Optional per-requester op counters enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int DATA_W      = 4,
    parameter int OP_W        = 4,
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  op_count0,
    output logic [CNT_W-1:0]  op_count1
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int EC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [EC_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                grant_any;
    logic                grant_id;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_any = (state_q == S_IDLE) && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    assign req0_ready = rst_n && grant_any && !grant_id;
    assign req1_ready = rst_n && grant_any && grant_id;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    alu_a_d      = grant_id ? req1_a  : req0_a;
                    alu_b_d      = grant_id ? req1_b  : req0_b;
                    alu_op_d     = grant_id ? req1_op : req0_op;
                    rsp_id_d     = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = EC_W'(EXEC_CYCLES - 1);
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_carry_d  = alu_carry;
                    rsp_zero_d   = alu_zero;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - EC_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] op_cnt0_q, op_cnt0_d;
    logic [CNT_W-1:0] op_cnt1_q, op_cnt1_d;

    // Saturating counts of accepted requests.
    always_comb begin
        op_cnt0_d = op_cnt0_q;
        op_cnt1_d = op_cnt1_q;
        if (grant_any && !grant_id && (op_cnt0_q != '1)) begin
            op_cnt0_d = op_cnt0_q + CNT_W'(1);
        end
        if (grant_any && grant_id && (op_cnt1_q != '1)) begin
            op_cnt1_d = op_cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt0_q <= '0;
            op_cnt1_q <= '0;
        end else begin
            op_cnt0_q <= op_cnt0_d;
            op_cnt1_q <= op_cnt1_d;
        end
    end

    assign op_count0 = op_cnt0_q;
    assign op_count1 = op_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

    localparam int DW   = 4;
    localparam int OW   = 4;
    localparam int EXEC = 2;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OW-1:0] req0_op, req1_op;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [OW-1:0] alu_opcode;
    logic          alu_carry, alu_zero;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero;
    logic [DW-1:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
    logic [CW-1:0] op_count0, op_count1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW), .OP_W(OW), .EXEC_CYCLES(EXEC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
        , .op_count0(op_count0), .op_count1(op_count1)
`endif
    );

    // Opcodes: 0 add, 1 sub (carry=borrow), 2 and, 3 or, 4 xor, 5 mul, 6 div (b=0 gives 15).
    function automatic logic [5:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        int ia, ib, r;
        logic c;
        ia = int'(a);
        ib = int'(b);
        c  = 1'b0;
        case (op)
            4'd0: begin r = ia + ib; c = (r > 15); end
            4'd1: begin r = ia - ib; c = (ia < ib); end
            4'd2: r = ia & ib;
            4'd3: r = ia | ib;
            4'd4: r = ia ^ ib;
            4'd5: begin r = ia * ib; c = (r > 15); end
            4'd6: r = (ib == 0) ? 15 : ia / ib;
            default: r = 0;
        endcase
        r = r & 15;
        return {c, (r == 0), r[3:0]};
    endfunction

    always_comb {alu_carry, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_opcode);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        #1;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
    endtask

    task automatic do_single(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                             input logic [3:0] er, input logic ec, input logic ez);
        int n;
        rsp_ready = 1'b1;
        set_req(id, 1'b1, a, b, op);
        #1;
        chk("single_ready_grant", id ? req1_ready : req0_ready, 1);
        chk("single_ready_other", id ? req0_ready : req1_ready, 0);
        tick();
        set_req(id, 1'b0, 4'd0, 4'd0, 4'd0);
        #1;
        chk("exec_ready0", req0_ready, 0);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        chk("exec_alu_op", alu_opcode, op);
        wait_rsp(n);
        chk("latency_edges", n + 1, EXEC + 1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_result", rsp_result, er);
        chk("rsp_carry", rsp_carry, ec);
        chk("rsp_zero", rsp_zero, ez);
        tick();
        chk("rsp_retired", rsp_valid, 0);
    endtask

    typedef struct {
        logic       id;
        logic [3:0] a, b, op, res;
        logic       c, z;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n;
        int grants[$];
        logic [4:0] rsps[$];
        logic pend[2];
        logic [3:0] pa[2], pb[2], pop[2];
        logic busy, model_last, exp_id;
        logic [5:0] exp_alu;
        logic [3:0] ea, eb, eop;
        int age, nrsp;

        tbl[0] = '{id: 1'b0, a: 4'd7,  b: 4'd8, op: 4'd0, res: 4'd15, c: 1'b0, z: 1'b0};
        tbl[1] = '{id: 1'b1, a: 4'd5,  b: 4'd5, op: 4'd1, res: 4'd0,  c: 1'b0, z: 1'b1};
        tbl[2] = '{id: 1'b0, a: 4'd9,  b: 4'd8, op: 4'd0, res: 4'd1,  c: 1'b1, z: 1'b0};
        tbl[3] = '{id: 1'b1, a: 4'd3,  b: 4'd5, op: 4'd1, res: 4'd14, c: 1'b1, z: 1'b0};
        tbl[4] = '{id: 1'b0, a: 4'd3,  b: 4'd4, op: 4'd5, res: 4'd12, c: 1'b0, z: 1'b0};
        tbl[5] = '{id: 1'b1, a: 4'd9,  b: 4'd3, op: 4'd6, res: 4'd3,  c: 1'b0, z: 1'b0};
        tbl[6] = '{id: 1'b0, a: 4'd12, b: 4'd3, op: 4'd2, res: 4'd0,  c: 1'b0, z: 1'b1};
        tbl[7] = '{id: 1'b1, a: 4'd8,  b: 4'd2, op: 4'd5, res: 4'd0,  c: 1'b1, z: 1'b1};

        set_req(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        set_req(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        req0_valid = 1'b1;
        #1;
        chk("reset_ready0", req0_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_op", alu_opcode, 0);
        chk("reset_rsp_result", rsp_result, 0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_single(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res, tbl[i].c, tbl[i].z);
        end

        // Contention: both requesters continuously valid.
        do_reset();
        set_req(1'b0, 1'b1, 4'd3, 4'd4, 4'd5);
        set_req(1'b1, 1'b1, 4'd9, 4'd3, 4'd6);
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && (grants.size() < 4 || rsps.size() < 4); cyc++) begin
            #1;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp_valid) rsps.push_back({rsp_id, rsp_result});
            tick();
        end
        chk("rr_grant_count", grants.size() >= 4, 1);
        chk("rr_rsp_count", rsps.size() >= 4, 1);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("rr_grant_order", grants[i], i % 2);
        for (int i = 0; i < 4 && i < rsps.size(); i++)
            chk("rr_rsp", rsps[i], (i % 2 == 1) ? {1'b1, 4'd3} : {1'b0, 4'd12});

        // Backpressure.
        do_reset();
        set_req(1'b0, 1'b1, 4'd7, 4'd8, 4'd0);
        set_req(1'b1, 1'b1, 4'd5, 4'd5, 4'd1);
        #1;
        chk("bp_first_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        wait_rsp(n);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_rsp_result", rsp_result, 15);
            chk("bp_readys", {req0_ready, req1_ready}, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        #1;
        chk("bp_retired", rsp_valid, 0);
        chk("bp_pending_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        wait_rsp(n);
        chk("bp_second_id", rsp_id, 1);
        chk("bp_second_zero", {rsp_zero, rsp_result}, {1'b1, 4'd0});
        tick();

        // Reset in the middle of an op issued by requester 0.
        set_req(1'b0, 1'b1, 4'd6, 4'd7, 4'd0);
        #1;
        chk("mid_ready0", req0_ready, 1);
        tick();
        set_req(1'b0, 1'b1, 4'd1, 4'd2, 4'd0);
        set_req(1'b1, 1'b1, 4'd3, 4'd4, 4'd0);
        rst_n = 1'b0;
        tick();
        chk("mid_alu", {alu_a, alu_b, alu_opcode}, 0);
        chk("mid_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero}, 0);
        chk("mid_readys", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * EXEC + 4; i++) begin
            if (rsp_valid) n++;
            tick();
        end
        chk("mid_no_response", n, 0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("mid_tie_ready0", req0_ready, 1);
        chk("mid_tie_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(n);
        chk("mid_after_result", rsp_result, 3);
        tick();

        // Randomized traffic against a transaction-level model.
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        pa = '{4'd0, 4'd0}; pb = '{4'd0, 4'd0}; pop = '{4'd0, 4'd0};
        busy = 1'b0; model_last = 1'b1; age = 0; nrsp = 0;
        ea = 4'd0; eb = 4'd0; eop = 4'd0; exp_alu = 6'd0; exp_id = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    pa[i]   = 4'($urandom_range(0, 15));
                    pb[i]   = 4'($urandom_range(0, 15));
                    pop[i]  = 4'($urandom_range(0, 7));
                end
                set_req(i[0], pend[i], pa[i], pb[i], pop[i]);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (busy) age++;
            if (!busy && (pend[0] || pend[1])) begin
                exp_id = (pend[0] && pend[1]) ? !model_last : pend[1];
                chk("rand_ready0", req0_ready, !exp_id);
                chk("rand_ready1", req1_ready, exp_id);
                ea = pa[exp_id]; eb = pb[exp_id]; eop = pop[exp_id];
                exp_alu = alu_fn(ea, eb, eop);
                model_last = exp_id;
                pend[exp_id] = 1'b0;
                busy = 1'b1;
                age = 0;
            end else begin
                chk("rand_readys_idle", {req0_ready, req1_ready}, 0);
                if (busy) begin
                    chk("rand_alu_hold", {alu_a, alu_b, alu_opcode}, {ea, eb, eop});
                    if (age <= EXEC) begin
                        chk("rand_rsp_early", rsp_valid, 0);
                    end else begin
                        chk("rand_rsp_valid", rsp_valid, 1);
                        chk("rand_rsp", {rsp_id, rsp_carry, rsp_zero, rsp_result}, {exp_id, exp_alu});
                        if (rsp_ready) begin
                            busy = 1'b0;
                            nrsp++;
                        end
                    end
                end else begin
                    chk("rand_rsp_idle", rsp_valid, 0);
                end
            end
            tick();
        end
        chk("rand_enough_rsps", nrsp > 40, 1);

`ifdef ALU_ARB_STATS_EN
        do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("stats_reset0", op_count0, 0);
        for (int i = 0; i < 5; i++) do_single(1'b0, 4'd1, 4'd1, 4'd0, 4'd2, 1'b0, 1'b0);
        chk("stats_sat0", op_count0, 3);
        chk("stats_cnt1", op_count1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
